mem_block_copy: RTL and testbench
=================================

# mem_block_copy

Block-transfer initiator for the 32K x 16 dual-port data memory. On a single `start` pulse it copies `length` consecutive words from `src_addr` to `dst_addr`. It reads through memory port A and writes through memory port B, and sustains one word per clock using the memory's one-cycle registered read latency. It sits beside the CPU as the memory's second master; the top level ties memory `port_a_we` low while the engine owns the ports.

## Interface
Parameters:
- `ADDR_W`, 15: memory address width; addresses wrap modulo 2^ADDR_W.
- `DATA_W`, 16: memory word width.

Ports:
- `clk`  in  1: single clock; all registers update on its rising edge.
- `rst_n`  in  1: reset, asynchronous and active-low.
- `start`  in  1: one-cycle request; sampled only when `busy`=0.
- `src_addr`  in  15: first source word address, latched on an accepted `start`.
- `dst_addr`  in  15: first destination word address, latched on an accepted `start`.
- `length`  in  15: number of words to copy; 0 means no-op.
- `busy`  out  1: transfer in progress.
- `done`  out  1: one-cycle completion pulse.
- `mem_a_address`  out  15: read address driven to memory port A; registered.
- `mem_a_out`  in  16: memory port A read data, valid one cycle after the address is sampled.
- `mem_b_address`  out  15: write address driven to memory port B; registered.
- `mem_b_in`  out  16: write data, a combinational pass-through of `mem_a_out`.
- `mem_b_we`  out  1: write enable driven to memory port B; registered.
- `checksum`  out  16: present only with `MEM_BLOCK_COPY_CHECKSUM_EN` (see Configuration).

## Operation
- FSM states:
  - IDLE: `busy`=0. A `start` with `length`≠0 latches the arguments, sets `mem_a_address`=src and `rd_cnt`=1, then enters RUN. A `start` with `length`=0 gives `done`=1 for one cycle, stays in IDLE and performs no write.
  - RUN: each cycle, while `rd_cnt`<L, `mem_a_address` increments by 1 and `rd_cnt` increments. `mem_b_we`=1 from the second RUN cycle onward; `mem_b_address` starts at dst and increments after each write. When the write of word L-1 is presented, the FSM enters LAST.
  - LAST: the final write edge occurs. On that edge `mem_b_we`→0, `busy`→0, `done`→1, and the FSM returns to IDLE.
- `start` while `busy`=1 is ignored; no latching and no error.
- Addresses wrap: 0x7FFF+1 = 0x0000 on both ports. `length` up to 32767 is supported.
- Overlapping copies:
  - `dst` ≤ `src`, or `dst` = `src`+1, yields a correct copy, because the memory reads old data on a same-edge write.
  - `src`+1 < `dst` < `src`+L is unsupported; the result is unchecked.
- Reset asserted mid-transfer: all outputs clear immediately. Words already written stay written; the remaining words are abandoned and no `done` is produced.

## Timing
- Reset values: `busy`=0, `done`=0, `mem_b_we`=0, `mem_a_address`=0, `mem_b_address`=0, `checksum`=0, FSM=IDLE.
- Edge numbering: start is accepted at edge E0.
  - From E0: `busy`=1 and `mem_a_address`=src.
  - At E1: the memory captures mem[src].
  - After E1: `mem_b_we`=1, `mem_b_address`=dst, `mem_b_in`=mem[src].
- Word k is read at edge E(k+1) and written at edge E(k+2). The last write occurs at edge E(L+1).
- `done` is high for exactly the cycle following E(L+1). `busy` is high from E0 to E(L+1), i.e. L+1 cycles.
- A new `start` can be accepted in the cycle in which `done` is high. That gives back-to-back transfers with zero idle cycles.
- `length`=0: `done` is high in the cycle after E0; `busy` never rises.

## Configuration
- `MEM_BLOCK_COPY_CHECKSUM_EN`
  - Defined: adds output `checksum`. It clears to 0 on an accepted `start` and adds each written word modulo 2^16 on every write edge. Its final value is valid when `done`=1 and is held until the next accepted `start` or reset.
  - Undefined: the port and its adder are absent. All other behaviour is identical.

## Test plan
- Basic copy: preload mem[0x0100..0x0103] = 0x1111, 0x2222, 0x3333, 0x4444; start src=0x0100, dst=0x0200, L=4.
  - Required: mem[0x0200..0x0203] matches the source; `done` is high exactly 5 cycles after the start edge; `mem_b_we` is high for 4 cycles.
  - With the macro: `checksum`=0xAAAA.
- Wrap-around: src=0x7FFE, dst=0x7FFF, L=3, with mem[0x7FFE]=0xA, mem[0x7FFF]=0xB, mem[0x0000]=0xC.
  - Required: mem[0x7FFF]=0xA, mem[0x0000]=0xB, mem[0x0001]=0xC. This also exercises the `dst`=`src`+1 overlap.
- Zero length: start with L=0.
  - Required: `done` is high for 1 cycle, `busy` stays 0, `mem_b_we` is never asserted.
- Ignored start and back-to-back:
  - Pulse `start` (L=2) mid-transfer of L=8: it is ignored, and exactly 8 writes occur.
  - Then start L=2 in the `done` cycle: it is accepted, with writes resuming 2 cycles later.
- Reset mid-transfer: assert `rst_n`=0 after 3 writes of an L=10 copy.
  - Required: `mem_b_we` and `busy` drop with no clock edge; only dst..dst+2 are modified; no `done` pulse.

Source files
------------

// File: rtl/mem_block_copy_if.sv
// Memory-side bus of the block-copy engine: port A read path and port B write path.
interface mem_block_copy_if #(
    parameter int unsigned ADDR_W = 15,
    parameter int unsigned DATA_W = 16
);
    logic [ADDR_W-1:0] mem_a_address;
    logic [DATA_W-1:0] mem_a_out;
    logic [ADDR_W-1:0] mem_b_address;
    logic [DATA_W-1:0] mem_b_in;
    logic              mem_b_we;

    modport master (
        output mem_a_address,
        input  mem_a_out,
        output mem_b_address,
        output mem_b_in,
        output mem_b_we
    );

    modport slave (
        input  mem_a_address,
        output mem_a_out,
        input  mem_b_address,
        input  mem_b_in,
        input  mem_b_we
    );
endinterface

// File: rtl/mem_block_copy.sv
// Block-transfer initiator: streams length words src->dst at one word per clock.
// Optional running checksum of written words enabled by MEM_BLOCK_COPY_CHECKSUM_EN.
module mem_block_copy #(
    parameter int unsigned ADDR_W = 15,
    parameter int unsigned DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [ADDR_W-1:0] length,
    output logic              busy,
    output logic              done,
`ifdef MEM_BLOCK_COPY_CHECKSUM_EN
    output logic [DATA_W-1:0] checksum,
`endif
    mem_block_copy_if.master  mem
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_LAST = 2'd2
    } state_e;

    state_e            state_q,   state_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [ADDR_W-1:0] len_q,     len_d;
    logic [ADDR_W-1:0] rd_cnt_q,  rd_cnt_d;
    logic [ADDR_W-1:0] wr_cnt_q,  wr_cnt_d;
    logic              we_q,      we_d;
    logic              busy_q,    busy_d;
    logic              done_q,    done_d;
`ifdef MEM_BLOCK_COPY_CHECKSUM_EN
    logic [DATA_W-1:0] cks_q,     cks_d;
`endif

    // Next-state logic; wr_cnt tracks the index of the word presented on port B.
    always_comb begin
        state_d   = state_q;
        rd_addr_d = rd_addr_q;
        wr_addr_d = wr_addr_q;
        len_d     = len_q;
        rd_cnt_d  = rd_cnt_q;
        wr_cnt_d  = wr_cnt_q;
        we_d      = we_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
`ifdef MEM_BLOCK_COPY_CHECKSUM_EN
        cks_d     = cks_q;
        if (we_q) begin
            cks_d = cks_q + mem.mem_a_out;
        end
`endif

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
`ifdef MEM_BLOCK_COPY_CHECKSUM_EN
                    cks_d = '0;
`endif
                    if (length == '0) begin
                        done_d = 1'b1;
                    end else begin
                        len_d     = length;
                        rd_addr_d = src_addr;
                        wr_addr_d = dst_addr;
                        rd_cnt_d  = ADDR_W'(1);
                        wr_cnt_d  = '0;
                        busy_d    = 1'b1;
                        state_d   = ST_RUN;
                    end
                end
            end

            ST_RUN: begin
                we_d = 1'b1;
                if (rd_cnt_q < len_q) begin
                    rd_addr_d = rd_addr_q + ADDR_W'(1);
                    rd_cnt_d  = rd_cnt_q + ADDR_W'(1);
                end
                if (we_q) begin
                    wr_addr_d = wr_addr_q + ADDR_W'(1);
                    wr_cnt_d  = wr_cnt_q + ADDR_W'(1);
                end
                if (wr_cnt_d == len_q - ADDR_W'(1)) begin
                    state_d = ST_LAST;
                end
            end

            ST_LAST: begin
                we_d      = 1'b0;
                busy_d    = 1'b0;
                done_d    = 1'b1;
                wr_addr_d = wr_addr_q + ADDR_W'(1);
                state_d   = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            rd_addr_q <= '0;
            wr_addr_q <= '0;
            len_q     <= '0;
            rd_cnt_q  <= '0;
            wr_cnt_q  <= '0;
            we_q      <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
`ifdef MEM_BLOCK_COPY_CHECKSUM_EN
            cks_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            rd_addr_q <= rd_addr_d;
            wr_addr_q <= wr_addr_d;
            len_q     <= len_d;
            rd_cnt_q  <= rd_cnt_d;
            wr_cnt_q  <= wr_cnt_d;
            we_q      <= we_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
`ifdef MEM_BLOCK_COPY_CHECKSUM_EN
            cks_q     <= cks_d;
`endif
        end
    end

    assign busy              = busy_q;
    assign done              = done_q;
    assign mem.mem_a_address = rd_addr_q;
    assign mem.mem_b_address = wr_addr_q;
    assign mem.mem_b_we      = we_q;
    // Read data flows straight to the write port; the memory's read latency aligns it.
    assign mem.mem_b_in      = mem.mem_a_out;
`ifdef MEM_BLOCK_COPY_CHECKSUM_EN
    assign checksum          = cks_q;
`endif

endmodule

// File: tb/tb_mem_block_copy.sv
// Self-checking bench for mem_block_copy: behavioural memory plus snapshot copy model.
module tb_mem_block_copy;

    localparam int unsigned AW    = 15;
    localparam int unsigned DW    = 16;
    localparam int unsigned DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [AW-1:0] src_addr;
    logic [AW-1:0] dst_addr;
    logic [AW-1:0] length;
    logic          busy;
    logic          done;
`ifdef MEM_BLOCK_COPY_CHECKSUM_EN
    logic [DW-1:0] checksum;
`endif

    mem_block_copy_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    mem_block_copy #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .src_addr (src_addr),
        .dst_addr (dst_addr),
        .length   (length),
        .busy     (busy),
        .done     (done),
`ifdef MEM_BLOCK_COPY_CHECKSUM_EN
        .checksum (checksum),
`endif
        .mem      (bus)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] mem     [DEPTH];
    logic [DW-1:0] ref_mem [DEPTH];
    logic [DW-1:0] ref_cks;
    int            n_checks = 0;
    int            n_errors = 0;

    // Dual-port memory: registered read on A, write on B, read returns old data on collision.
    always @(posedge clk) begin
        bus.mem_a_out <= mem[bus.mem_a_address];
        if (bus.mem_b_we) mem[bus.mem_b_address] <= bus.mem_b_in;
    end

    function automatic logic [AW-1:0] wrap(input logic [AW-1:0] a, input int k);
        return AW'(32'(a) + k);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Copy semantics: all source words as they were at start, first nwr of them land at dst.
    task automatic model_copy(input logic [AW-1:0] s, input logic [AW-1:0] d, input int len, input int nwr);
        logic [DW-1:0] snap[$];
        for (int k = 0; k < len; k++) snap.push_back(ref_mem[wrap(s, k)]);
        ref_cks = '0;
        for (int k = 0; k < nwr; k++) begin
            ref_mem[wrap(d, k)] = snap[k];
            ref_cks = ref_cks + snap[k];
        end
    endtask

    task automatic check_mem(input string tag, input logic [AW-1:0] d, input int len);
        int diff = 0;
        for (int k = 0; k < len; k++)
            check($sformatf("%s_w%0d", tag, k), 32'(mem[wrap(d, k)]), 32'(ref_mem[wrap(d, k)]));
        for (int i = 0; i < int'(DEPTH); i++)
            if (mem[i] !== ref_mem[i]) diff++;
        check({tag, "_image"}, 32'(diff), 32'd0);
    endtask

    // Called at a negedge; returns at the negedge following the accepting edge.
    task automatic launch(input logic [AW-1:0] s, input logic [AW-1:0] d, input logic [AW-1:0] l);
        start = 1'b1; src_addr = s; dst_addr = d; length = l;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Samples one cycle per negedge (n = cycles after the accepting edge) until done.
    task automatic watch(input int len, input int ign_at,
                         output int done_at, output int we_cnt, output int busy_cnt, output int first_we);
        done_at = -1; we_cnt = 0; busy_cnt = 0; first_we = -1;
        for (int n = 0; n <= len + 8; n++) begin
            if (n > 0) @(negedge clk);
            if (n == ign_at) begin
                start = 1'b1; src_addr = AW'($urandom); dst_addr = 15'h6000; length = 15'd2;
            end else begin
                start = 1'b0;
            end
            if (busy) busy_cnt++;
            if (bus.mem_b_we) begin
                we_cnt++;
                if (first_we < 0) first_we = n;
            end
            if (done) begin
                done_at = n;
                break;
            end
        end
        start = 1'b0;
    endtask

    task automatic check_timing(input string tag, input int len, input int done_at,
                                input int we_cnt, input int busy_cnt, input int first_we);
        check({tag, "_done_at"}, 32'(done_at),  32'((len == 0) ? 0 : len + 1));
        check({tag, "_we_cnt"},  32'(we_cnt),   32'(len));
        check({tag, "_busy_cnt"},32'(busy_cnt), 32'((len == 0) ? 0 : len + 1));
        check({tag, "_first_we"},32'(first_we), 32'((len == 0) ? -1 : 1));
    endtask

    task automatic run_one(input string tag, input logic [AW-1:0] s, input logic [AW-1:0] d, input int len);
        int done_at, we_cnt, busy_cnt, first_we;
        @(negedge clk);
        launch(s, d, AW'(len));
        watch(len, -1, done_at, we_cnt, busy_cnt, first_we);
        model_copy(s, d, len, len);
        check_timing(tag, len, done_at, we_cnt, busy_cnt, first_we);
`ifdef MEM_BLOCK_COPY_CHECKSUM_EN
        if (len > 0) check({tag, "_cks"}, 32'(checksum), 32'(ref_cks));
`endif
        check_mem(tag, d, len);
        @(negedge clk);
        check({tag, "_done_width"}, 32'(done), 32'd0);
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int done_at, we_cnt, busy_cnt, first_we;
        logic [AW-1:0] s, d, diff;
        int len;

        rst_n = 1'b0; start = 1'b0; src_addr = '0; dst_addr = '0; length = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            mem[i]     = DW'($urandom);
            ref_mem[i] = mem[i];
        end
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_we",   32'(bus.mem_b_we), 32'd0);
        check("rst_a",    32'(bus.mem_a_address), 32'd0);
        check("rst_b",    32'(bus.mem_b_address), 32'd0);
`ifdef MEM_BLOCK_COPY_CHECKSUM_EN
        check("rst_cks",  32'(checksum), 32'd0);
`endif
        rst_n = 1'b1;

        // Basic copy of four known words.
        mem[15'h0100] = 16'h1111; mem[15'h0101] = 16'h2222;
        mem[15'h0102] = 16'h3333; mem[15'h0103] = 16'h4444;
        for (int i = 'h100; i < 'h104; i++) ref_mem[i] = mem[i];
        run_one("basic", 15'h0100, 15'h0200, 4);
        check("basic_w3_lit", 32'(mem[15'h0203]), 32'h4444);
`ifdef MEM_BLOCK_COPY_CHECKSUM_EN
        check("basic_cks_lit", 32'(checksum), 32'hAAAA);
`endif

        // Wrap-around with dst = src + 1.
        mem[15'h7FFE] = 16'h000A; mem[15'h7FFF] = 16'h000B; mem[15'h0000] = 16'h000C;
        ref_mem[15'h7FFE] = 16'h000A; ref_mem[15'h7FFF] = 16'h000B; ref_mem[15'h0000] = 16'h000C;
        run_one("wrap", 15'h7FFE, 15'h7FFF, 3);
        check("wrap_7fff", 32'(mem[15'h7FFF]), 32'h000A);
        check("wrap_0001", 32'(mem[15'h0001]), 32'h000C);

        run_one("zero", 15'h0123, 15'h0456, 0);

        // Ignored start mid-transfer, then a back-to-back start in the done cycle.
        @(negedge clk);
        launch(15'h1000, 15'h2000, 15'd8);
        watch(8, 3, done_at, we_cnt, busy_cnt, first_we);
        model_copy(15'h1000, 15'h2000, 8, 8);
        check_timing("ign", 8, done_at, we_cnt, busy_cnt, first_we);
        check("ign_done_now", 32'(done), 32'd1);
        launch(15'h2002, 15'h3000, 15'd2);
        watch(2, -1, done_at, we_cnt, busy_cnt, first_we);
        model_copy(15'h2002, 15'h3000, 2, 2);
        check_timing("b2b", 2, done_at, we_cnt, busy_cnt, first_we);
`ifdef MEM_BLOCK_COPY_CHECKSUM_EN
        check("b2b_cks", 32'(checksum), 32'(ref_cks));
`endif
        check_mem("b2b", 15'h3000, 2);
        check_mem("ign", 15'h2000, 8);

        // Reset after three writes of a ten-word copy.
        @(negedge clk);
        launch(15'h4000, 15'h5000, 15'd10);
        repeat (4) @(negedge clk);
        check("mid_we_before", 32'(bus.mem_b_we), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_busy", 32'(busy), 32'd0);
        check("mid_we",   32'(bus.mem_b_we), 32'd0);
        check("mid_done", 32'(done), 32'd0);
`ifdef MEM_BLOCK_COPY_CHECKSUM_EN
        check("mid_cks",  32'(checksum), 32'd0);
`endif
        repeat (2) begin
            @(negedge clk);
            check("mid_no_done", 32'(done), 32'd0);
        end
        rst_n = 1'b1;
        model_copy(15'h4000, 15'h5000, 10, 3);
        check_mem("mid", 15'h5000, 10);

        // Random transfers avoiding the unsupported forward-overlap window.
        for (int t = 0; t < 10; t++) begin
            len = (t == 9) ? 200 : int'($urandom_range(1, 40));
            do begin
                s = AW'($urandom);
                d = AW'($urandom);
                if ($urandom_range(0, 2) == 0) d = wrap(s, int'($urandom_range(0, 3)) - 2);
                diff = d - s;
            end while (32'(diff) >= 2 && 32'(diff) < 32'(len));
            run_one($sformatf("rnd%0d", t), s, d, len);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
